// File: rtl/status_register_unit.sv
`default_nettype none
// ============================================================================
//  Module   : status_register_unit
//  Purpose  : Architectural N Z C V status flag register. Captures EX-stage
//             ALU flags for S-bit instructions or takes a direct MSR-style
//             write. Presents the flags to the ID-stage condition check,
//             either forwarded from EX (BYPASS=1) or from the register only
//             with a read-after-write hazard raised (BYPASS=0). A saturating
//             counter records hazard stall cycles.
//  Ports    :
//    clk           in   system clock, rising edge
//    rst_n         in   synchronous active-low reset
//    freeze        in   pipeline stall, holds all state
//    flush         in   squashes the EX instruction's flag write
//    exe_valid     in   EX stage holds a real instruction
//    exe_s         in   EX instruction updates flags
//    exe_nzcv      in   [3:0] ALU flags from EX (N Z C V, MSB first)
//    msr_we        in   direct flag write enable
//    msr_data      in   [3:0] direct flag write value
//    id_valid      in   ID stage holds a real instruction
//    id_cond       in   [3:0] condition field of the ID instruction
//    hcnt_clr      in   clears the hazard counter
//    sr_out        out  [3:0] flags presented to the condition check
//    flag_hazard   out  ID must stall this cycle
//    hazard_count  out  [HCNT_W-1:0] hazard stall cycle count (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module status_register_unit #(
    parameter bit         BYPASS   = 1'b1,
    parameter logic [3:0] RESET_SR = 4'b0000,
    parameter int         HCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              exe_valid,
    input  logic              exe_s,
    input  logic [3:0]        exe_nzcv,
    input  logic              msr_we,
    input  logic [3:0]        msr_data,
    input  logic              id_valid,
    input  logic [3:0]        id_cond,
    input  logic              hcnt_clr,
    output logic [3:0]        sr_out,
    output logic              flag_hazard,
    output logic [HCNT_W-1:0] hazard_count
);

    // Condition codes that never consult the flags.
    localparam logic [3:0]        c_cond_al  = 4'b1110;
    localparam logic [3:0]        c_cond_nv  = 4'b1111;
    localparam logic [HCNT_W-1:0] c_hcnt_max = '1;
    localparam logic [HCNT_W-1:0] c_hcnt_one = HCNT_W'(1);

    logic [3:0]        r_sr;
    logic [HCNT_W-1:0] r_hcnt;

    logic       w_ex_wr;
    logic       w_id_needs;
    logic       w_sr_wr;
    logic [3:0] w_sr_next;
    logic       w_hazard;

    // A flushed EX instruction is treated as if it had no S bit.
    assign w_ex_wr    = exe_valid & exe_s & ~flush;
    assign w_id_needs = id_valid & (id_cond != c_cond_al) & (id_cond != c_cond_nv);
    assign w_sr_wr    = msr_we | w_ex_wr;

    // MSR write wins over a simultaneous EX write. The same mux feeds both
    // the register and the forwarding path so they can never disagree.
    always_comb begin
        w_sr_next = r_sr;
        if (msr_we) begin
            w_sr_next = msr_data;
        end else if (w_ex_wr) begin
            w_sr_next = exe_nzcv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr <= RESET_SR;
        end else if (!freeze) begin
            r_sr <= w_sr_next;
        end
    end

    // With forwarding there is nothing to wait for, so the hazard is tied
    // off; without it, any pending write blocks a flag-reading ID.
    assign w_hazard    = ~BYPASS & w_id_needs & w_sr_wr;
    assign flag_hazard = w_hazard;
    assign sr_out      = BYPASS ? w_sr_next : r_sr;

    // Clear beats freeze; frozen hazard cycles are not stall cycles caused
    // by this block, so they are not counted.
    always_ff @(posedge clk) begin
        if (!rst_n || hcnt_clr) begin
            r_hcnt <= '0;
        end else if (w_hazard && !freeze && (r_hcnt != c_hcnt_max)) begin
            r_hcnt <= r_hcnt + c_hcnt_one;
        end
    end

    assign hazard_count = r_hcnt;

endmodule
`default_nettype wire

// File: tb/tb_status_register_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_status_register_unit
//  Purpose  : Self-checking bench. Two instances share all inputs: one
//             without forwarding (4-bit counter) and one with forwarding.
//             A flag/counter model is compared every cycle, and directed
//             literal expectations pin the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_status_register_unit;

    localparam int c_nb_w = 4;
    localparam int c_bp_w = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, freeze, flush, exe_valid, exe_s, msr_we;
    logic       id_valid, hcnt_clr;
    logic [3:0] exe_nzcv, msr_data, id_cond;

    logic [3:0]        nb_sr_out, bp_sr_out;
    logic              nb_hazard, bp_hazard;
    logic [c_nb_w-1:0] nb_hcnt;
    logic [c_bp_w-1:0] bp_hcnt;

    status_register_unit #(.BYPASS(1'b0), .RESET_SR(4'b0000), .HCNT_W(c_nb_w)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .exe_valid(exe_valid), .exe_s(exe_s), .exe_nzcv(exe_nzcv),
        .msr_we(msr_we), .msr_data(msr_data), .id_valid(id_valid),
        .id_cond(id_cond), .hcnt_clr(hcnt_clr), .sr_out(nb_sr_out),
        .flag_hazard(nb_hazard), .hazard_count(nb_hcnt)
    );

    status_register_unit #(.BYPASS(1'b1), .RESET_SR(4'b0000), .HCNT_W(c_bp_w)) u_dut_bp (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .exe_valid(exe_valid), .exe_s(exe_s), .exe_nzcv(exe_nzcv),
        .msr_we(msr_we), .msr_data(msr_data), .id_valid(id_valid),
        .id_cond(id_cond), .hcnt_clr(hcnt_clr), .sr_out(bp_sr_out),
        .flag_hazard(bp_hazard), .hazard_count(bp_hcnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: architectural flag value and counter as integers.
    // ------------------------------------------------------------------
    logic [3:0] m_sr;
    int         m_hcnt;
    bit         m_valid = 1'b0;

    function automatic bit m_writes_flags();
        return msr_we || (exe_valid && exe_s && !flush);
    endfunction

    // The flags ID would see if the pending write were already architectural.
    function automatic logic [3:0] m_newest_flags();
        if (msr_we) return msr_data;
        if (exe_valid && exe_s && !flush) return exe_nzcv;
        return m_sr;
    endfunction

    function automatic bit m_id_reads_flags();
        return id_valid && !(id_cond inside {4'hE, 4'hF});
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sr    <= 4'b0000;
            m_hcnt  <= 0;
            m_valid <= 1'b1;
        end else begin
            if (!freeze) m_sr <= m_newest_flags();
            if (hcnt_clr)
                m_hcnt <= 0;
            else if (!freeze && m_id_reads_flags() && m_writes_flags())
                m_hcnt <= (m_hcnt + 1 > (1 << c_nb_w) - 1) ? (1 << c_nb_w) - 1 : m_hcnt + 1;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("nb_sr_out", nb_sr_out, m_sr);
            check("nb_hazard", nb_hazard, m_id_reads_flags() && m_writes_flags());
            check("nb_hcnt",   nb_hcnt,   m_hcnt);
            check("bp_sr_out", bp_sr_out, m_newest_flags());
            check("bp_hazard", bp_hazard, 1'b0);
            check("bp_hcnt",   bp_hcnt,   32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs after an input change, still before negedge.
    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; exe_valid = 1'b1; exe_s = 1'b1;
        exe_nzcv = 4'b1111; msr_we = 1'b0; msr_data = 4'b0000; id_valid = 1'b0;
        id_cond = 4'b0000; hcnt_clr = 1'b0;

        // Reset held two edges while an S instruction sits in EX.
        step(); step(); settle();
        check("lit_rst_sr",   nb_sr_out, 4'b0000);
        check("lit_rst_hcnt", nb_hcnt,   4'd0);
        rst_n = 1'b1;
        step(); settle();
        check("lit_release_sr", nb_sr_out, 4'b1111);

        // S-bit capture, no capture without S, MSR priority.
        exe_nzcv = 4'b0100;
        step(); settle();
        check("lit_capture", nb_sr_out, 4'b0100);
        exe_s = 1'b0; exe_nzcv = 4'b1000;
        step(); settle();
        check("lit_no_s", nb_sr_out, 4'b0100);
        msr_we = 1'b1; msr_data = 4'b0011; exe_s = 1'b1; exe_nzcv = 4'b1100;
        settle();
        check("lit_bp_msr_fwd", bp_sr_out, 4'b0011);
        step();
        msr_we = 1'b0; exe_s = 1'b0;
        settle();
        check("lit_msr_wins", nb_sr_out, 4'b0011);

        // Flushed write with a flag-reading ID instruction.
        exe_s = 1'b1; flush = 1'b1; exe_nzcv = 4'b0001; id_valid = 1'b1; id_cond = 4'b0000;
        settle();
        check("lit_flush_hazard", nb_hazard, 1'b0);
        check("lit_flush_bp",     bp_sr_out, 4'b0011);
        step();
        flush = 1'b0; exe_s = 1'b0; id_valid = 1'b0;
        settle();
        check("lit_flush_sr", nb_sr_out, 4'b0011);

        // Freeze for three cycles with a pending write.
        freeze = 1'b1; exe_s = 1'b1; exe_nzcv = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            check("lit_freeze_hold", nb_sr_out, 4'b0011);
        end
        freeze = 1'b0;
        step(); settle();
        check("lit_freeze_release", nb_sr_out, 4'b1010);

        // Forwarding vs hazard from flags 0000.
        exe_s = 1'b0; msr_we = 1'b1; msr_data = 4'b0000;
        step();
        msr_we = 1'b0; exe_s = 1'b1; exe_nzcv = 4'b0100; id_valid = 1'b1; id_cond = 4'b0000;
        settle();
        check("lit_bp_fwd",    bp_sr_out, 4'b0100);
        check("lit_bp_nohaz",  bp_hazard, 1'b0);
        check("lit_nb_haz",    nb_hazard, 1'b1);
        check("lit_nb_old_sr", nb_sr_out, 4'b0000);
        step();
        exe_s = 1'b0;
        settle();
        check("lit_nb_new_sr", nb_sr_out, 4'b0100);
        check("lit_nb_haz_gone", nb_hazard, 1'b0);
        check("lit_nb_hcnt1",  nb_hcnt,   4'd1);

        // AL / NV conditions do not read flags.
        exe_s = 1'b1; exe_nzcv = 4'b1001; id_cond = 4'b1110;
        settle();
        check("lit_al_nohaz", nb_hazard, 1'b0);
        id_cond = 4'b1111;
        settle();
        check("lit_nv_nohaz", nb_hazard, 1'b0);
        id_cond = 4'b0001;
        settle();
        check("lit_ne_haz", nb_hazard, 1'b1);

        // Frozen hazard cycles are not counted.
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) step();
        settle();
        check("lit_frozen_hcnt", nb_hcnt, 4'd1);
        freeze = 1'b0;

        // Saturation: 20 more hazard cycles from 1 would exceed 15.
        for (int i = 0; i < 20; i++) begin
            exe_nzcv = 4'(i);
            step();
        end
        settle();
        check("lit_sat", nb_hcnt, 4'd15);
        step(); step(); settle();
        check("lit_sat_hold", nb_hcnt, 4'd15);

        // Clear beats a live hazard.
        hcnt_clr = 1'b1;
        step();
        hcnt_clr = 1'b0;
        settle();
        check("lit_clr", nb_hcnt, 4'd0);
        step(); settle();
        check("lit_count_after_clr", nb_hcnt, 4'd1);

        // Mid-stream reset overrides freeze and MSR write.
        rst_n = 1'b0; freeze = 1'b1; msr_we = 1'b1; msr_data = 4'b1111;
        step();
        rst_n = 1'b1; freeze = 1'b0; msr_we = 1'b0; exe_s = 1'b0; id_valid = 1'b0;
        settle();
        check("lit_midrst_sr",   nb_sr_out, 4'b0000);
        check("lit_midrst_hcnt", nb_hcnt,   4'd0);

        // Back-to-back S instructions: newest wins each edge.
        exe_s = 1'b1;
        exe_nzcv = 4'b0110; step();
        exe_nzcv = 4'b1001; step();
        exe_s = 1'b0;
        settle();
        check("lit_b2b", nb_sr_out, 4'b1001);

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/status_register_unit.md
# status_register_unit

Holds the architectural N Z C V status flags and drives the 4-bit SR bus (bit order N Z C V, MSB first) into the ID-stage condition check. Flags are captured at the end of EX when the executing instruction has its S bit set, or are written directly by an MSR-style write port. The block also detects flag read-after-write hazards against the ID instruction. A saturating counter records hazard stall cycles for performance analysis.

## Interface
Parameters:
- BYPASS, 1: 1 means EX flag results are forwarded combinationally to `sr_out`; 0 means no forwarding, and a hazard is raised instead.
- RESET_SR, 4'b0000: NZCV value loaded on reset.
- HCNT_W, 16: width of the hazard counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- freeze  in  1  pipeline stall (SRAM wait); holds all state.
- flush  in  1  squashes the EX instruction (taken branch); its flags are not written.
- exe_valid  in  1  EX stage holds a real instruction.
- exe_s  in  1  EX instruction updates flags.
- exe_nzcv  in  4  ALU flags from EX, ordered N Z C V.
- msr_we  in  1  direct flag write.
- msr_data  in  4  value for the direct write.
- id_valid  in  1  ID stage holds a real instruction.
- id_cond  in  4  condition field of the ID instruction.
- hcnt_clr  in  1  clears the hazard counter.
- sr_out  out  4  flags presented to the condition check.
- flag_hazard  out  1  ID must stall this cycle.
- hazard_count  out  HCNT_W  number of hazard stall cycles.

## Operation
Definitions:
- ex_wr = exe_valid & exe_s & ~flush.
- id_needs = id_valid & (id_cond != 4'b1110) & (id_cond != 4'b1111). The AL and NV conditions never read flags.

Register `sr_q`, next-state priority (highest first):
1. rst_n = 0: load RESET_SR.
2. freeze = 1: hold.
3. msr_we = 1: load msr_data. This wins over a simultaneous ex_wr, and the EX value is discarded.
4. ex_wr = 1: load exe_nzcv.
5. Otherwise: hold.

`sr_out`:
- BYPASS = 1: msr_we ? msr_data : ex_wr ? exe_nzcv : sr_q.
  - This priority matches the register priority, so `sr_out` equals the next `sr_q` whenever freeze = 0.
  - When freeze = 1, the same mux is still presented. ID is also frozen, so the value seen there is not consumed.
- BYPASS = 0: `sr_out` = sr_q.

`flag_hazard`:
- BYPASS = 1: constant 0.
- BYPASS = 0: id_needs & (ex_wr | msr_we).
- Asserted independently of freeze. The pipeline control ORs it with the other stall sources.

Hazard counter `hcnt`, next-state priority:
1. rst_n = 0, or hcnt_clr = 1: 0.
2. flag_hazard & ~freeze: increment, saturating at 2^HCNT_W - 1. It holds at all-ones and does not wrap.
3. Otherwise: hold.

`hazard_count` = hcnt.

The flush input affects only the EX write. A flushed EX instruction never raises a hazard and never reaches `sr_out`.

## Timing
- Reset values: sr_q = RESET_SR, so sr_out = RESET_SR. flag_hazard = 0 once the inputs are idle. hazard_count = 0.
- Reset is sampled only at the clock edge. Asserting it mid-stream overrides freeze, msr_we and ex_wr in that same cycle.
- Flag write latency: the value is visible in sr_q at the edge that ends the EX cycle.
  - BYPASS = 1: ID sees the new flags with zero cycles of extra latency.
  - BYPASS = 0: ID sees them exactly one cycle later, after one hazard cycle.
- Back-to-back S instructions: each edge loads the newest EX value. There is no queuing.
- freeze held for N cycles: sr_q and hcnt are unchanged for all N cycles. The pending write lands on the first edge where freeze = 0, provided the inputs are still presented.
- sr_out and flag_hazard are purely combinational from the inputs and sr_q. There is no output register.

## Test plan
- Reset: drive rst_n = 0 for 2 cycles with exe_valid = exe_s = 1 and exe_nzcv = 4'b1111 → sr_q = 0000 and hazard_count = 0. Release reset; the next edge gives sr_q = 1111.
- S-bit capture and priority:
  - exe_nzcv = 4'b0100 with exe_s = 1 → sr_q = 0100 after one edge.
  - Next, exe_s = 0 with exe_nzcv = 4'b1000 → sr_q stays 0100.
  - Same cycle msr_we = 1, msr_data = 4'b0011, and ex_wr with exe_nzcv = 4'b1100 → sr_q = 0011.
- Flush and freeze:
  - ex_wr inputs with flush = 1 and exe_nzcv = 4'b0001 → sr_q unchanged and flag_hazard = 0 (BYPASS = 0).
  - freeze = 1 for 3 cycles with exe_nzcv = 4'b1010 → sr_q held; on release it becomes 1010.
- BYPASS = 1 forwarding: sr_q = 0000, ex_wr with exe_nzcv = 4'b0100, id_cond = 4'b0000 → sr_out = 0100 in the same cycle and flag_hazard = 0.
- BYPASS = 0 hazard:
  - Same stimulus as the forwarding case → flag_hazard = 1 and sr_out = 0000. The next cycle (EX idle) gives sr_out = 0100, flag_hazard = 0 and hazard_count = 1.
  - With id_cond = 4'b1110 or 4'b1111 → flag_hazard = 0.
- Counter saturation: with HCNT_W = 4, hold a hazard for 20 cycles with freeze = 0 → hazard_count = 15 and stays at 15. Frozen hazard cycles do not count. hcnt_clr = 1 → 0 on the next edge.
